// File: rtl/alu_result_stage_pkg.sv
// alu_result_stage_pkg: flag bit positions and skid buffer state encoding shared by the result stage
package alu_result_stage_pkg;
   localparam int FLAG_N = 3;
   localparam int FLAG_V = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_C = 0;
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} buf_state_t;
endpackage

// File: rtl/skid_buf2.sv
// skid_buf2: 2-entry in-order FIFO whose in_ready is registered, so it never depends on out_ready
module skid_buf2
   import alu_result_stage_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   buf_state_t state, state_nx;
   logic [W-1:0] d0, d1;
   logic rdy, push, pop;
   assign push = in_valid & rdy;
   assign pop = (state != EMPTY) & out_ready;
   assign in_ready = rdy;
   assign out_valid = state != EMPTY;
   assign out_data = d0;
   always_comb begin
      state_nx = state;
      case (state)
         EMPTY:   state_nx = push ? ONE : EMPTY;
         ONE:     state_nx = (push && !pop) ? FULL : (pop && !push) ? EMPTY : ONE;
         FULL:    state_nx = pop ? ONE : FULL;
         default: state_nx = EMPTY;
      endcase
   end
   // d0 always holds the oldest entry; rdy stays low through reset and rises on the first edge after
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
         rdy   <= 1'b0;
         d0    <= '0;
         d1    <= '0;
      end else begin
         state <= state_nx;
         rdy   <= state_nx != FULL;
         if (push && (state == EMPTY || pop)) d0 <= in_data;
         else if (pop) d0 <= d1;
         if (push && state == ONE && !pop) d1 <= in_data;
      end
   end
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: buffers ALU results, keeps the {N,V,Z,C} flag register with chained-Z support,
// and counts accepted results
module alu_result_stage
   import alu_result_stage_pkg::*;
#(
   parameter int n  = 31,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [n:0]    do_in,
   input  logic          N_in,
   input  logic          V_in,
   input  logic          Z_in,
   input  logic          C_in,
   input  logic          flag_we,
   input  logic          chain,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [n:0]    out_data,
   output logic [3:0]    flags,
   output logic          cin_fb,
   output logic [CW-1:0] op_count
);
   logic acc;
   assign acc = in_valid & in_ready;
   assign cin_fb = flags[FLAG_C];
   skid_buf2 #(.W(n + 1)) u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (do_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data)
   );
   // a chained upper word only keeps Z set if every lower word was zero too
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags    <= '0;
         op_count <= '0;
      end else begin
         if (acc) op_count <= op_count + CW'(1);
         if (acc && flag_we) begin
            flags[FLAG_N] <= N_in;
            flags[FLAG_V] <= V_in;
            flags[FLAG_Z] <= Z_in & (~chain | flags[FLAG_Z]);
            flags[FLAG_C] <= C_in;
         end
      end
   end
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: queue-based reference model compared every cycle, plus hand-computed scenario checks
module tb_alu_result_stage;
   localparam int N = 31;
   localparam int CW = 8;
   logic clk = 1'b0, rst_n = 1'b1;
   logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, cin_fb;
   logic [N:0] do_in = '0, out_data;
   logic N_in = 1'b0, V_in = 1'b0, Z_in = 1'b0, C_in = 1'b0, flag_we = 1'b0, chain = 1'b0;
   logic [3:0] flags;
   logic [CW-1:0] op_count;
   int vecs = 0, errs = 0;
   logic [N:0] mq[$];
   bit mrdy = 1'b0, macc;
   logic [3:0] mflags = '0;
   int mcnt = 0;

   always #5 clk = ~clk;

   alu_result_stage #(.n(N), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .do_in(do_in),
      .N_in(N_in), .V_in(V_in), .Z_in(Z_in), .C_in(C_in), .flag_we(flag_we), .chain(chain),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .flags(flags), .cin_fb(cin_fb), .op_count(op_count)
   );

   // reference: a bounded queue of pending results plus plain flag/count arithmetic
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         mrdy = 1'b0;
         mflags = '0;
         mcnt = 0;
      end else begin
         macc = in_valid && mrdy;
         if (mq.size() > 0 && out_ready) void'(mq.pop_front());
         if (macc) begin
            mq.push_back(do_in);
            mcnt = (mcnt + 1) % (1 << CW);
            if (flag_we) mflags = {N_in, V_in, Z_in && (!chain || mflags[1]), C_in};
         end
         mrdy = mq.size() < 2;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      chk("model in_ready", in_ready, mrdy);
      chk("model out_valid", out_valid, mq.size() > 0);
      if (mq.size() > 0) chk("model out_data", out_data, mq[0]);
      if (!rst_n) chk("reset out_data", out_data, 0);
      chk("model flags", flags, mflags);
      chk("model cin_fb", cin_fb, mflags[0]);
      chk("model op_count", op_count, mcnt);
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic setf(input logic n_, input logic v_, input logic z_, input logic c_, input logic ch);
      N_in = n_; V_in = v_; Z_in = z_; C_in = c_; chain = ch;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst in_ready", in_ready, 0);
      chk("rst out_valid", out_valid, 0);
      chk("rst out_data", out_data, 0);
      chk("rst flags", flags, 0);
      chk("rst op_count", op_count, 0);
      rst_n = 1'b1;
      step();
      chk("ready after release", in_ready, 1);
      // single result with carry set
      in_valid = 1; do_in = 32'h0000_0005; flag_we = 1; setf(0, 0, 0, 1, 0); out_ready = 1;
      step();
      in_valid = 0;
      chk("first out_valid", out_valid, 1);
      chk("first out_data", out_data, 32'h5);
      chk("first flags", flags, 4'b0001);
      chk("first cin_fb", cin_fb, 1);
      chk("first op_count", op_count, 1);
      step();
      // backpressure: A, B fill the buffer, C waits
      flag_we = 0; out_ready = 0; in_valid = 1; do_in = 32'hAAAA_0001;
      step();
      chk("bp ready after A", in_ready, 1);
      chk("bp head A", out_data, 32'hAAAA_0001);
      do_in = 32'hBBBB_0002;
      step();
      chk("bp ready after B", in_ready, 0);
      chk("bp head still A", out_data, 32'hAAAA_0001);
      do_in = 32'hCCCC_0003;
      step();
      chk("bp C held", in_ready, 0);
      chk("bp head A held", out_data, 32'hAAAA_0001);
      out_ready = 1;
      step();
      chk("bp head B", out_data, 32'hBBBB_0002);
      chk("bp ready reopens", in_ready, 1);
      step();
      in_valid = 0;
      chk("bp head C", out_data, 32'hCCCC_0003);
      step();
      chk("bp drained", out_valid, 0);
      chk("bp op_count", op_count, 4);
      // chained Z
      in_valid = 1; flag_we = 1; setf(0, 0, 1, 0, 0);
      step();
      chk("chain w0 Z", flags[1], 1);
      setf(0, 0, 0, 0, 1);
      step();
      chk("chain w1 Z", flags[1], 0);
      setf(0, 0, 1, 0, 0);
      step();
      chk("chain2 w0 Z", flags[1], 1);
      setf(0, 0, 1, 0, 1);
      step();
      chk("chain2 w1 Z", flags[1], 1);
      setf(0, 0, 0, 0, 0);
      step();
      setf(0, 0, 1, 0, 1);
      step();
      chk("chain after zero Z", flags[1], 0);
      // flag_we=0 holds flags but still counts
      setf(1, 0, 1, 0, 0);
      step();
      chk("flags 1010", flags, 4'b1010);
      flag_we = 0; setf(0, 1, 0, 1, 1);
      step();
      in_valid = 0;
      chk("flags held", flags, 4'b1010);
      chk("count with flag_we=0", op_count, 12);
      // counter wrap
      rst_n = 0; #3 rst_n = 1;
      step();
      in_valid = 1; out_ready = 1;
      repeat ((1 << CW) - 1) step();
      chk("count max", op_count, (1 << CW) - 1);
      step();
      chk("count wrap", op_count, 0);
      // reset while full
      flag_we = 1; setf(1, 1, 0, 1, 0); out_ready = 0;
      step();
      step();
      in_valid = 0;
      chk("full in_ready", in_ready, 0);
      chk("full flags", flags, 4'b1101);
      rst_n = 0;
      #1;
      chk("async out_valid", out_valid, 0);
      chk("async flags", flags, 0);
      chk("async cin_fb", cin_fb, 0);
      chk("async in_ready", in_ready, 0);
      chk("async out_data", out_data, 0);
      chk("async op_count", op_count, 0);
      step();
      rst_n = 1; out_ready = 1;
      repeat (3) begin
         step();
         chk("no stale after reset", out_valid, 0);
      end
      // randomized traffic
      repeat (3000) begin
         in_valid = $urandom_range(0, 3) != 0;
         out_ready = $urandom_range(0, 2) != 0;
         do_in = $urandom;
         flag_we = $urandom_range(0, 1);
         setf($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
         step();
      end
      in_valid = 0; out_ready = 1;
      repeat (3) step();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
